// File: rtl/img_packer_121.sv
// img_packer_121 -- collects a stream of NPIX pixels into one packed image
// word and hands it to the 121x32x10 network with a single-cycle start pulse.
// It then waits for the network's prediction-done before accepting more pixels.
//
// Parameters
//   NPIX    pixels per image
//   PW      bits per pixel
//   THRESH  binarize threshold (only meaningful with PACKER_BINARIZE_EN)
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous reset, active low
//   pix_in      pixel data
//   pix_valid   pixel data valid
//   pix_sof     start-of-frame, qualified by pix_valid
//   pix_ready   packer accepts a pixel this cycle
//   img_source  packed image, pixel 0 in the LSBs
//   valid_top   one-cycle start pulse to the network
//   ready_top   prediction-done from the network
//   img_count   completed images handed to the network (wraps)
//   sof_err     sticky: a frame was restarted before it completed
//
// Build option
//   PACKER_BINARIZE_EN  when defined, each stored pixel becomes all-ones if
//                       pix_in >= THRESH, otherwise zero.
module img_packer_121 #(
  parameter int NPIX   = 121,
  parameter int PW     = 8,
  parameter int THRESH = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PW-1:0]      pix_in,
  input  logic               pix_valid,
  input  logic               pix_sof,
  output logic               pix_ready,
  output logic [NPIX*PW-1:0] img_source,
  output logic               valid_top,
  input  logic               ready_top,
  output logic [15:0]        img_count,
  output logic               sof_err
);

  localparam int            IW       = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);

  typedef enum logic [1:0] {
    FILL,
    FIRE,
    WAIT
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] slot;
  logic          accept;
  logic          last_pix;

`ifdef PACKER_BINARIZE_EN
  function automatic logic [PW-1:0] store_pix(input logic [PW-1:0] p);
    return (32'(p) >= THRESH) ? '1 : '0;
  endfunction
`else
  function automatic logic [PW-1:0] store_pix(input logic [PW-1:0] p);
    return p;
  endfunction

  // THRESH only matters for the binarizing build.
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
`endif

  // Acceptance is derived from the state register directly so it does not
  // loop back through the output decode below.
  assign accept = pix_valid && (state_q == FILL);

  // A start-of-frame pixel always lands in slot 0, restarting the frame.
  assign slot     = pix_sof ? '0 : idx_q;
  assign last_pix = (slot == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // ready_top is only looked at in WAIT; a done seen during FIRE belongs to
  // the previous image.
  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    valid_top = 1'b0;
    case (state_q)
      FILL: begin
        pix_ready = 1'b1;
        if (accept && last_pix) begin
          state_d = FIRE;
        end
      end
      FIRE: begin
        valid_top = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (ready_top) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Image slots change only on accepted pixels, so the image stays frozen
  // from FIRE until the packer is back in FILL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      img_source <= '0;
      img_count  <= '0;
      sof_err    <= 1'b0;
    end else begin
      if (accept) begin
        img_source[slot*PW +: PW] <= store_pix(pix_in);
        idx_q                     <= last_pix ? '0 : slot + IW'(1);
        if (pix_sof && (idx_q != '0)) begin
          sof_err <= 1'b1;
        end
      end
      if (state_q == FIRE) begin
        img_count <= img_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_img_packer_121.sv
// Bench for img_packer_121: a frame-level reference model (a pixel list per
// frame) predicts each completed image and the control outputs; a monitor
// compares them against the design every cycle.
module tb_img_packer_121;

  localparam int NPIX = 121;
  localparam int PW   = 8;
  localparam int W    = NPIX * PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          ready_top = 1'b0;
  logic          pix_ready;
  logic [W-1:0]  img_source;
  logic          valid_top;
  logic [15:0]   img_count;
  logic          sof_err;

  always #5 clk = ~clk;

  img_packer_121 #(.NPIX(NPIX), .PW(PW), .THRESH(128)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .img_source (img_source),
    .valid_top  (valid_top),
    .ready_top  (ready_top),
    .img_count  (img_count),
    .sof_err    (sof_err)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  typedef enum {COLLECT, ANNOUNCE, AWAIT} phase_t;
  phase_t        m_phase = COLLECT;
  logic [PW-1:0] frame_q[$];
  logic [W-1:0]  sb_q[$];
  logic [15:0]   m_count = '0;
  logic          m_err = 1'b0;

  function automatic logic [PW-1:0] expect_store(input logic [PW-1:0] p);
`ifdef PACKER_BINARIZE_EN
    return (p >= 8'd128) ? 8'hFF : 8'h00;
`else
    return p;
`endif
  endfunction

  initial begin
    logic [W-1:0] img;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_phase = COLLECT;
        frame_q.delete();
        sb_q.delete();
        m_count = '0;
        m_err   = 1'b0;
      end else begin
        case (m_phase)
          COLLECT: begin
            if (pix_valid) begin
              if (pix_sof) begin
                if (frame_q.size() != 0) m_err = 1'b1;
                frame_q.delete();
              end
              frame_q.push_back(expect_store(pix_in));
              if (frame_q.size() == NPIX) begin
                img = '0;
                for (int i = 0; i < NPIX; i++) img[i*PW +: PW] = frame_q[i];
                sb_q.push_back(img);
                frame_q.delete();
                m_phase = ANNOUNCE;
              end
            end
          end
          ANNOUNCE: begin
            m_count = m_count + 16'd1;
            m_phase = AWAIT;
          end
          AWAIT: begin
            if (ready_top) m_phase = COLLECT;
          end
          default: m_phase = COLLECT;
        endcase
      end
    end
  end

  // ---------------- comparison helpers ----------------
  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_img(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    int first;
    checks++;
    if (act !== exp) begin
      failures++;
      first = 0;
      for (int i = 0; i < NPIX; i++) begin
        if (act[i*PW +: PW] !== exp[i*PW +: PW]) begin
          first = i;
          break;
        end
      end
      $display("FAIL %s slot=%0d actual=%h required=%h at %0t", name, first,
               act[first*PW +: PW], exp[first*PW +: PW], $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] hold_img = '0;
  bit           have_hold = 0;

  initial begin
    forever begin
      @(negedge clk);
      check_val("ctl", {45'd0, pix_ready, valid_top, img_count, sof_err},
                {45'd0, (m_phase == COLLECT), (m_phase == ANNOUNCE), m_count, m_err});
      if (!rst) have_hold = 0;
      if (valid_top) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid_top actual=1 required=0 at %0t", $time);
        end else begin
          hold_img  = sb_q.pop_front();
          have_hold = 1;
          check_img("image", img_source, hold_img);
        end
      end else if (m_phase != COLLECT && have_hold) begin
        check_img("image_hold", img_source, hold_img);
      end
    end
  end

  // ---------------- stimulus ----------------
  int rt_mode = 0;  // 0: hold ready_top low, 1: hold high, 2: random

  function automatic logic rt_next();
    case (rt_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return ($urandom_range(0, 3) == 0);
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof   = 1'($urandom_range(0, 1));
      pix_in    = 8'($urandom);
      ready_top = rt_next();
    end
  endtask

  task automatic send(input logic [PW-1:0] p, input logic sof);
    int  guard;
    bit  done;
    guard = 0;
    done  = 0;
    while (!done) begin
      @(negedge clk);
      ready_top = rt_next();
      if (m_phase == COLLECT) begin
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_in    = p;
        done      = 1;
      end else begin
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        guard++;
        if (guard > 300) begin
          checks++;
          failures++;
          $display("FAIL send_timeout actual=busy required=ready at %0t", $time);
          done = 1;
        end
      end
    end
  endtask

  task automatic random_frame(input bit edge_pix);
    logic [PW-1:0] v;
    for (int i = 0; i < NPIX; i++) begin
      idle($urandom_range(0, 2));
      v = 8'($urandom);
      if (edge_pix && i == 5) v = 8'd127;
      if (edge_pix && i == 6) v = 8'd128;
      send(v, (i == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    rt_mode = 0;
    idle(3);
    check_img("reset_img", img_source, '0);
    check_val("reset_ctl", {60'd0, pix_ready, valid_top, sof_err}, 64'b100);
    check_val("reset_count", 64'(img_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Ramp frame 0..120, then a long WAIT with ready_top held low.
    for (int i = 0; i < NPIX; i++) send(8'(i), (i == 0));
    idle(52);
    check_val("wait_ready_low", 64'(pix_ready), 64'd0);
    rt_mode = 1;
    idle(1);
    rt_mode = 0;
    idle(1);
    check_val("released_ready", 64'(pix_ready), 64'd1);
    check_val("count_after_first", 64'(img_count), 64'd1);

    // Done asserted during FIRE must be ignored; WAIT then holds.
    rt_mode = 1;
    for (int i = 0; i < NPIX; i++) send(8'($urandom), 1'b0);
    idle(1);
    rt_mode = 0;
    idle(10);
    check_val("stale_done_ignored", 64'(pix_ready), 64'd0);
    rt_mode = 1;
    idle(1);

    // Frame restarted after 60 pixels.
    rt_mode = 2;
    for (int i = 0; i < 60; i++) send(8'($urandom), 1'b0);
    send(8'hA5, 1'b1);
    for (int i = 0; i < NPIX - 1; i++) send(8'($urandom), 1'b0);
    idle(3);
    check_val("sof_err_set", 64'(sof_err), 64'd1);
    check_val("count_after_restart", 64'(img_count), 64'd3);

    // Randomised frames with gaps, including the threshold edge pixels.
    random_frame(1'b1);
    random_frame(1'b0);
    random_frame(1'b0);
    idle(4);

    // Reset in the middle of a frame abandons it.
    for (int i = 0; i < 70; i++) send(8'($urandom), (i == 0));
    @(posedge clk);
    #2 rst = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    check_img("midframe_reset_img", img_source, '0);
    check_val("midframe_reset_ctl", {45'd0, pix_ready, valid_top, img_count, sof_err}, 64'h40000);
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    idle(5);
    check_val("no_fire_after_reset", 64'(img_count), 64'd0);
    random_frame(1'b0);
    idle(3);
    check_val("count_after_reset_frame", 64'(img_count), 64'd1);
    idle(5);
    check_val("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/img_packer_121.md
IMG_PACKER_121 -- requirements
Module: img_packer_121

Interface
REQ-001 Parameter NPIX, default 121, number of pixels per image.
REQ-002 Parameter PW, default 8, bits per pixel.
REQ-003 Parameter THRESH, default 128, binarize threshold (used only with PACKER_BINARIZE_EN).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 pix_in  input  PW  pixel data.
REQ-007 pix_valid  input  1  pixel data valid.
REQ-008 pix_sof  input  1  start-of-frame flag, qualified by pix_valid.
REQ-009 pix_ready  output  1  packer accepts a pixel this cycle.
REQ-010 img_source  output  NPIX*PW  packed image to the 121x32x10 network top.
REQ-011 valid_top  output  1  one-cycle start pulse to the network.
REQ-012 ready_top  input  1  network prediction-done from the comparator.
REQ-013 img_count  output  16  completed images handed to the network.
REQ-014 sof_err  output  1  sticky flag: a frame restarted before completion.

Function
REQ-015 Pixel accepted iff pix_valid && pix_ready on a rising edge.
REQ-016 FSM states: FILL, FIRE, WAIT; FILL is the reset state.
REQ-017 In FILL, pix_ready=1; in FIRE and WAIT, pix_ready=0.
REQ-018 Pixel index counter idx (0..NPIX-1) selects the write slot: accepted pixel goes to img_source[idx*PW +: PW]; first pixel of a frame lands in LSBs.
REQ-019 Accepted pixel with pix_sof=1 is written at index 0 and sets idx=1, regardless of the current idx.
REQ-020 Accepted pixel with pix_sof=1 while idx!=0 sets sof_err=1; the partial frame is discarded and no valid_top is issued for it.
REQ-021 Accepted pixel with pix_sof=0 at idx=0 is written normally; sof is not mandatory.
REQ-022 Accepting the pixel at idx=NPIX-1: idx wraps to 0, FSM goes FILL->FIRE.
REQ-023 FIRE: valid_top=1 for exactly one cycle, img_count increments (wraps 65535->0), FSM goes to WAIT unconditionally.
REQ-024 Latency: valid_top high in the cycle immediately after the last pixel is accepted.
REQ-025 WAIT: FSM stays until ready_top sampled 1, then goes to FILL; the next pixel can be accepted in the following cycle.
REQ-026 ready_top high during FIRE is ignored (stale done from the previous image); only WAIT samples it.
REQ-027 img_source holds stable from the FIRE cycle until the WAIT->FILL transition; slots are overwritten only by newly accepted pixels.
REQ-028 pix_sof without pix_valid has no effect.

Reset
REQ-029 rst low asynchronously forces FSM=FILL, idx=0, img_source=0, valid_top=0, img_count=0, sof_err=0; pix_ready is 1 while in FILL.
REQ-030 Reset asserted mid-frame or in WAIT abandons the image; no valid_top follows reset release.
REQ-031 sof_err is cleared only by reset.

Configuration
REQ-032 Macro PACKER_BINARIZE_EN: when defined, each accepted pixel is stored as {PW{1'b1}} if pix_in >= THRESH, else 0.
REQ-033 When PACKER_BINARIZE_EN is undefined, pix_in is stored unmodified; THRESH is unused.

Verification
REQ-034 Reset, then stream pixels 0..120 (value = index) with valid high every cycle -> valid_top pulses 1 cycle after the 121st accept; img_source[i*8+:8]=i; img_count=1.
REQ-035 In WAIT, hold ready_top=0 for 50 cycles -> pix_ready=0 and img_source unchanged throughout; ready_top=1 -> pix_ready=1 on the next cycle.
REQ-036 Send 60 pixels, then a pixel with pix_sof=1, then 120 more -> sof_err=1, exactly one valid_top, slot 0 holds the sof pixel value.
REQ-037 ready_top=1 during FIRE, then 0 in WAIT -> FSM remains in WAIT, no new pixels accepted.
REQ-038 With PACKER_BINARIZE_EN, pixels 127 and 128 -> stored 0x00 and 0xFF; without it -> stored 0x7F and 0x80.
REQ-039 Assert rst at pixel 70 -> all outputs at reset values, a following full frame yields img_count=1.
